// File: rtl/bram_port1_dma.sv
// Streaming DMA initiator for port 1 of the shared dual-port data buffer.
// One command runs at a time. Write mode moves an input valid/ready stream
// into consecutive buffer words. Read mode moves consecutive buffer words out
// on a valid/ready stream through a 2-entry skid FIFO that absorbs the
// one-cycle read latency of the buffer.
module bram_port1_dma #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 32,
    parameter int MEM_SIZE = 3840,
    parameter int LWIDTH   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [AWIDTH-1:0] cmd_base,
    input  logic [LWIDTH-1:0] cmd_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_d,
    input  logic [DWIDTH-1:0] mem_q
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR   = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]        state;
    logic [AWIDTH-1:0] base;
    logic [LWIDTH-1:0] len;
    logic [LWIDTH-1:0] idx;        // beat index in WR, read-issue index in RD
    logic [LWIDTH-1:0] out_idx;    // words popped from the skid FIFO
    logic              err_r;
    logic              inflight;   // a read was issued last cycle; mem_q is valid now
    logic [DWIDTH-1:0] fifo_mem [2];
    logic              fifo_head;
    logic [1:0]        fifo_count;

    logic              accept;
    logic              range_bad;
    logic              pop;
    logic              rd_issue;
    logic              last_out;
    logic [AWIDTH:0]   end_addr;
    logic [2:0]        occupancy;

    assign accept = cmd_valid && cmd_ready;

    // One extra bit so a base near the top of the address space cannot wrap
    // around and slip past the bound.
    assign end_addr  = {1'b0, cmd_base} + (AWIDTH+1)'(cmd_len);
    assign range_bad = end_addr > (AWIDTH+1)'(MEM_SIZE);

    assign pop       = m_valid && m_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign last_out  = (out_idx == len - LWIDTH'(1));

    // Words buffered plus the word in flight never exceed two. A pop in the
    // same cycle frees a slot, which keeps one word per cycle when the
    // consumer never stalls.
    assign rd_issue = (state == RD) && (idx < len) &&
                      ((occupancy - {2'b00, pop}) < 3'd2);

    // Handshake, status and buffer-port outputs decoded from the state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned and a latch is never inferred.
        cmd_ready = rst_n && (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == FIN);
        err       = (state == FIN) && err_r;
        s_ready   = (state == WR);
        m_valid   = (fifo_count != 2'd0);
        m_data    = fifo_mem[fifo_head];
        m_last    = m_valid && last_out;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_d     = '0;
        case (state)
            WR: begin
                mem_ce   = s_valid;
                mem_we   = 1'b1;
                mem_addr = base + AWIDTH'(idx);
                mem_d    = s_data;
            end
            RD: begin
                mem_ce   = rd_issue;
                mem_addr = base + AWIDTH'(idx);
            end
            default: ;
        endcase
    end

    // Command sequencing: accept, range check, beat/word counting, completion.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state    <= IDLE;
            base     <= '0;
            len      <= '0;
            idx      <= '0;
            out_idx  <= '0;
            err_r    <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_issue;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base    <= cmd_base;
                        len     <= cmd_len;
                        idx     <= '0;
                        out_idx <= '0;
                        err_r   <= range_bad;
                        if (range_bad || (cmd_len == '0)) state <= FIN;
                        else if (cmd_dir)                 state <= RD;
                        else                              state <= WR;
                    end
                end
                WR: begin
                    if (s_valid) begin
                        idx <= idx + LWIDTH'(1);
                        if (idx == len - LWIDTH'(1)) state <= FIN;
                    end
                end
                RD: begin
                    if (rd_issue) idx <= idx + LWIDTH'(1);
                    if (pop) begin
                        out_idx <= out_idx + LWIDTH'(1);
                        if (last_out) state <= FIN;
                    end
                end
                default: state <= IDLE;   // FIN: single-cycle done pulse
            endcase
        end
    end

    // Skid FIFO: capture mem_q the cycle after each read, release on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the two FIFO entries are reset explicitly so m_data reads
        // zero out of reset; this is cheap only because the storage is tiny.
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_head   <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            // A push never meets a full FIFO: the issue rule caps
            // fifo_count + inflight at two.
            if (inflight) fifo_mem[fifo_head ^ fifo_count[0]] <= mem_q;
            if (pop)      fifo_head <= ~fifo_head;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_port1_dma.sv
// Self-checking bench for bram_port1_dma: a command table plus hand-written
// sequences for busy-time commands and reset during a read. Writes and read
// words are checked against scoreboard queues filled when stimulus is driven.
module tb_bram_port1_dma;

    localparam int DWIDTH   = 32;
    localparam int AWIDTH   = 32;
    localparam int MEM_SIZE = 3840;
    localparam int LWIDTH   = 16;
    localparam int NVEC     = 13;

    typedef struct {
        logic        dir;
        int          base;
        int          len;
        logic        stall;     // write: gaps in s_valid; read: m_ready backpressure
        logic        exp_err;
        logic [31:0] data0;     // nonzero: write data0+i, zero: random data
    } vec_t;

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wr_t;

    typedef struct {
        logic [DWIDTH-1:0] data;
        logic              last;
    } rd_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cmd_valid, cmd_ready, cmd_dir;
    logic [AWIDTH-1:0] cmd_base;
    logic [LWIDTH-1:0] cmd_len;
    logic              busy, done, err;
    logic              s_valid, s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              m_valid, m_ready, m_last;
    logic [DWIDTH-1:0] m_data;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_ce, mem_we;
    logic [DWIDTH-1:0] mem_d;
    logic [DWIDTH-1:0] mem_q = '0;

    logic [DWIDTH-1:0] bram   [MEM_SIZE];
    logic [DWIDTH-1:0] shadow [MEM_SIZE];
    wr_t               wq[$];
    rd_t               rq[$];
    vec_t              vecs [NVEC];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc, n_issued, n_popped, first_pop_cyc, last_evt_cyc, accept_cyc;
    int   mon_occ;
    bit   mon_pop;
    logic cur_dir = 1'b0;
    wr_t  mon_w;
    rd_t  mon_r;
    int   hs_done_cyc;

    bram_port1_dma #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE), .LWIDTH(LWIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer port 1: synchronous write, read data valid the cycle after ce.
    always @(posedge clk) begin
        if (mem_ce && (mem_addr < MEM_SIZE)) begin
            if (mem_we) bram[mem_addr[11:0]] <= mem_d;
            else        mem_q <= bram[mem_addr[11:0]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: buffer accesses and popped words against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_occ = n_issued - n_popped;
            mon_pop = m_valid && m_ready;
            check("ce_outside_xfer", mem_ce && (!busy || done), 1'b0);
            if (cur_dir && busy) check("we_in_rd", mem_we, 1'b0);
            if (mem_ce) begin
                n_acc++;
                check("addr_range", mem_addr < MEM_SIZE, 1'b1);
                if (mem_we) begin
                    if (wq.size() == 0) check("unexpected_write", wq.size(), 1);
                    else begin
                        mon_w = wq.pop_front();
                        check("wr_addr", mem_addr, mon_w.addr);
                        check("wr_data", mem_d, mon_w.data);
                    end
                    last_evt_cyc = cyc;
                end else begin
                    check("rd_credit", (mon_occ - int'(mon_pop)) < 2, 1'b1);
                    n_issued++;
                end
            end
            if (mon_pop) begin
                check("fifo_bound", mon_occ <= 2, 1'b1);
                if (rq.size() == 0) check("unexpected_word", rq.size(), 1);
                else begin
                    mon_r = rq.pop_front();
                    check("rd_data", m_data, mon_r.data);
                    check("rd_last", m_last, mon_r.last);
                end
                if (n_popped == 0) first_pop_cyc = cyc;
                n_popped++;
                last_evt_cyc = cyc;
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_cmd(input logic dir, input int base, input int len);
        bit ready_seen = 0;
        n_acc = 0; n_issued = 0; n_popped = 0;
        first_pop_cyc = -1; last_evt_cyc = -1;
        cur_dir   = dir;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_base  = AWIDTH'(base);
        cmd_len   = LWIDTH'(len);
        for (int i = 0; i < 20 && !ready_seen; i++) begin
            @(negedge clk);
            if (cmd_ready) ready_seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk); #1;
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
    endtask

    task automatic stream_write(input int base, input int len, input logic gaps,
                                input logic [31:0] data0);
        logic [DWIDTH-1:0] val;
        wr_t               w;
        bit                beat_ok;
        for (int i = 0; i < len; i++) begin
            if (gaps && (i % 2 == 1)) begin
                s_valid = 1'b0;
                @(negedge clk);
                check("gap_no_ce", mem_ce, 1'b0);
                @(posedge clk); #1;
            end
            val = (data0 != 0) ? data0 + 32'(i) : $urandom();
            s_valid = 1'b1;
            s_data  = val;
            w.addr  = AWIDTH'(base + i);
            w.data  = val;
            wq.push_back(w);
            shadow[base + i] = val;
            beat_ok = 0;
            for (int t = 0; t < 20 && !beat_ok; t++) begin
                @(negedge clk);
                if (s_ready) beat_ok = 1;
                @(posedge clk); #1;
            end
            if (!beat_ok) check("s_ready_wr", s_ready, 1'b1);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err, input logic bp, output int done_cyc);
        bit pat [4];
        bit seen = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        done_cyc = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (bp) m_ready = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
            else    m_ready = 1'b1;
            @(negedge clk);
            if (done) begin
                seen     = 1;
                done_cyc = cyc;
                check("err", err, exp_err);
            end
            @(posedge clk); #1;
        end
        if (!seen) check("done_seen", done, 1'b1);
        else begin
            @(negedge clk);
            check("done_one_cycle", done, 1'b0);
            check("idle_after_done", {busy, cmd_ready}, 2'b01);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  exp_acc, done_cyc;
        rd_t r;
        exp_acc = v.exp_err ? 0 : v.len;
        if (v.dir && !v.exp_err) begin
            for (int i = 0; i < v.len; i++) begin
                r.data = shadow[v.base + i];
                r.last = (i == v.len - 1);
                rq.push_back(r);
            end
        end
        send_cmd(v.dir, v.base, v.len);
        if (!v.dir && !v.exp_err) stream_write(v.base, v.len, v.stall, v.data0);
        wait_done(v.exp_err, v.stall, done_cyc);
        check("access_count", n_acc, exp_acc);
        check("queues_drained", wq.size() + rq.size(), 0);
        if (exp_acc == 0) check("fin_latency", done_cyc - accept_cyc, 0);
        else              check("done_latency", done_cyc - last_evt_cyc, 1);
        if (v.dir && exp_acc != 0) begin
            check("words_out", n_popped, v.len);
            if (!v.stall) begin
                check("first_word_latency", first_pop_cyc - accept_cyc, 2);
                check("burst_back_to_back", last_evt_cyc - first_pop_cyc, v.len - 1);
            end
        end
    endtask

    initial begin
        //           dir    base        len stall  err    data0
        vecs[0]  = '{1'b0, 10,          4, 1'b0, 1'b0, 32'hA0};
        vecs[1]  = '{1'b1, 10,          4, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 3836,        4, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 3836,        4, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 3837,        4, 1'b0, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 3837,        4, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 5,           0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 0,           0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 100,         6, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 100,         6, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 3839,        1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 3839,        1, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, -1,          2, 1'b0, 1'b1, 32'h0};

        cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_flags", {cmd_ready, busy, done, err, s_ready, m_valid, m_last, mem_ce, mem_we}, 9'b0);
        check("rst_buses", {mem_addr, mem_d}, 64'b0);
        check("rst_m_data", m_data, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_out_of_reset", {cmd_ready, busy}, 2'b10);
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Command offered while busy is neither accepted nor remembered.
        send_cmd(1'b0, 200, 2);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_base = '0; cmd_len = LWIDTH'(1);
        @(negedge clk);
        check("cmd_ready_busy", {cmd_ready, busy}, 2'b01);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        stream_write(200, 2, 1'b0, 32'h5500);
        wait_done(1'b0, 1'b0, hs_done_cyc);
        check("busy_cmd_access_count", n_acc, 2);

        // Reset in the middle of a stalled read, then a normal read.
        m_ready = 1'b0;
        send_cmd(1'b1, 10, 4);
        repeat (6) @(posedge clk);
        #1;
        check("stall_issue_cap", n_issued, 2);
        check("stall_head_word", {m_valid, m_data}, {1'b1, 32'hA0});
        rst_n = 1'b0;
        #1;
        check("midrd_rst_flags", {cmd_ready, busy, done, err, s_ready, m_valid, m_last, mem_ce, mem_we}, 9'b0);
        check("midrd_rst_buses", {mem_addr, m_data}, 64'b0);
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", done, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {cmd_ready, busy}, 2'b10);
        @(posedge clk); #1;
        run_vec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port1_dma.md
Name: bram_port1_dma

Overview:
Streaming DMA initiator that owns port 1 (word-addressed) of the shared dual-port data buffer. It accepts one command at a time and runs in one of two directions. In write mode it moves a valid/ready input stream into consecutive buffer words. In read mode it moves consecutive buffer words out on a valid/ready output stream. It sits between the accelerator datapath streams and the buffer, while the CPU keeps port 0.

Parameters:
DWIDTH, 32, data word width
AWIDTH, 32, word-address width on port 1 and in cmd_base
MEM_SIZE, 3840, number of buffer words; legal word addresses are 0..MEM_SIZE-1
LWIDTH, 16, width of the transfer length field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_dir  in  1  0 = stream-to-buffer (write), 1 = buffer-to-stream (read)
cmd_base  in  AWIDTH  first word address
cmd_len  in  LWIDTH  number of words to move
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = command rejected
s_valid  in  1  write-stream data valid
s_ready  out  1  write-stream ready
s_data  in  DWIDTH  write-stream data
m_valid  out  1  read-stream data valid
m_ready  in  1  read-stream ready
m_data  out  DWIDTH  read-stream data
m_last  out  1  marks the final read word
mem_addr  out  AWIDTH  to buffer addr1 (word address)
mem_ce  out  1  to buffer ce1
mem_we  out  1  to buffer we1
mem_d  out  DWIDTH  to buffer d1
mem_q  in  DWIDTH  from buffer q1; valid the cycle after a read strobe

Behaviour:
- One clock, clk; reset is asynchronous, active-low on rst_n.
- Reset values:
  - state = IDLE.
  - cmd_ready=1 (it is 0 only while rst_n is low); busy, done, err, s_ready, m_valid, m_last, mem_ce, mem_we = 0.
  - mem_addr, mem_d, m_data = 0; counters and skid FIFO cleared.
  - Reset mid-transfer abandons the transfer. Words already written stay in the buffer. No done is produced.
- States: IDLE, WR, RD, FIN.
  - IDLE: cmd_ready=1. On accept, latch base, len and dir.
  - If base+len > MEM_SIZE (compare at AWIDTH+1 bits, no wrap): go to FIN with err=1. No memory access occurs.
  - Else if len==0: go to FIN with err=0.
  - Else go to WR or RD. busy=1 in every state except IDLE.
- WR:
  - s_ready=1.
  - mem_ce=s_valid, mem_we=1, mem_addr=base+idx, mem_d=s_data. These are combinational, so a beat is written in the same cycle it is accepted.
  - idx increments on each s_valid&&s_ready. After beat len-1, go to FIN.
  - s_valid low simply stalls; mem_ce=0 in those cycles.
- RD:
  - Issue a read (mem_ce=1, mem_we=0, mem_addr=base+rd_idx) when rd_idx<len and fifo_count+inflight<2. inflight is 0 or 1.
  - The cycle after an issue, mem_q is pushed into a 2-entry skid FIFO.
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last = m_valid && (out_idx==len-1).
  - A pop on m_valid&&m_ready increments out_idx.
  - With m_ready held high: first m_valid appears 2 cycles after accept, then one word per cycle.
  - With m_ready low: at most 2 words are buffered and no further reads are issued. No word is dropped or duplicated.
  - After the pop of word len-1, go to FIN.
- FIN: done=1 for exactly one cycle (err as determined above), then IDLE. cmd_ready=0 in FIN.
- cmd_valid outside IDLE is ignored and not latched.
- s_ready=0 outside WR; s_valid there is ignored.
- mem_we is never 1 in RD; mem_ce is never 1 in IDLE or FIN.
- Address arithmetic is AWIDTH bits. The range check guarantees no address reaches MEM_SIZE.

Test Plan:
- Write: cmd dir=0 base=10 len=4, s_data=A0..A3 back-to-back -> mem_ce/we high 4 cycles at addr 10,11,12,13 with A0..A3; done=1 err=0 one cycle later.
- Read with m_ready=1: after preloading words 10..13 via the write test, cmd dir=1 base=10 len=4 -> m_data A0..A3 on consecutive cycles starting 2 cycles after accept; m_last only with A3; done next cycle.
- Read backpressure: len=6, m_ready toggled 1,0,0,1,... randomly -> exactly 6 words in order; FIFO never exceeds 2; no read issued while fifo_count+inflight==2.
- Boundary: base=3836 len=4 -> accepted, addr 3836..3839; base=3837 len=4 -> done=1 err=1, mem_ce never asserted; len=0 -> done=1 err=0, no access.
- Stall/ignore: write with s_valid gaps -> mem_ce low during gaps, addresses contiguous; cmd_valid during busy -> not accepted, cmd_ready=0.
- Reset: assert rst_n=0 in the middle of RD -> all outputs 0 immediately, no done; a new command after release works normally.
